matmul_arbiter: RTL and testbench

- Shares one 2x2 8-bit matrix-multiply engine (start/done handshake, mat_A/mat_B in, mat_C out) between NUM_REQ requesters.
- Round-robin arbitration; captures the granted requester's operands, pulses engine start, waits for done, and returns the result with a per-requester valid pulse.
- A timeout counter flags a hung engine.
- Sits between accelerator front-ends (bus slave / DMA ports) and the multiply engine.

---
 rtl/matmul_pkg.sv | 39 +++
 rtl/matmul_arbiter_rr.sv | 32 +++
 rtl/matmul_arbiter.sv | 124 ++++++++++++
 tb/tb_matmul_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types for the 2x2 matrix-multiply arbiter: element/matrix types,
// controller state encoding and flat <-> array conversion helpers.
package matmul_pkg;

    localparam int ELEM_W_DEFAULT = 8;

    typedef logic [ELEM_W_DEFAULT-1:0]   elem_t;
    typedef elem_t [1:0][1:0]            mat2_t;
    typedef logic [4*ELEM_W_DEFAULT-1:0] mat2_flat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Flat packing is {m11, m10, m01, m00}, i.e. element [r][c] at slot 2*r+c.
    function automatic mat2_t unpack_mat(input mat2_flat_t flat);
        mat2_t m;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                m[r][c] = flat[(2*r+c)*ELEM_W_DEFAULT +: ELEM_W_DEFAULT];
            end
        end
        return m;
    endfunction

    function automatic mat2_flat_t pack_mat(input mat2_t m);
        mat2_flat_t flat;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                flat[(2*r+c)*ELEM_W_DEFAULT +: ELEM_W_DEFAULT] = m[r][c];
            end
        end
        return flat;
    endfunction

endpackage

// File: rtl/matmul_arbiter_rr.sv
// Combinational round-robin pick: first active request at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int               pos;
            logic [IDX_W-1:0] cand;
            pos = int'(rr_ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = IDX_W'(pos);
            if (!any && req[cand]) begin
                any          = 1'b1;
                gnt_idx      = cand;
                gnt_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_arbiter.sv
// Shares one 2x2 matrix-multiply engine between NUM_REQ requesters with
// round-robin arbitration, operand capture, result return and a hang timeout.
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ELEM_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*4*ELEM_W-1:0]   op_a,
    input  logic [NUM_REQ*4*ELEM_W-1:0]   op_b,
    output logic [NUM_REQ-1:0]            ack,
    output logic [4*ELEM_W-1:0]           res_c,
    output logic [NUM_REQ-1:0]            res_valid,
    output logic                          res_err,
    output logic                          busy,
    output logic                          eng_start,
    output logic [1:0][1:0][ELEM_W-1:0]   eng_mat_a,
    output logic [1:0][1:0][ELEM_W-1:0]   eng_mat_b,
    input  logic [1:0][1:0][ELEM_W-1:0]   eng_mat_c,
    input  logic                          eng_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MAT_W = 4 * ELEM_W;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (eng_done || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        res_valid = '0;
        eng_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ISSUE: begin
                ack       = gnt_oh;
                eng_start = 1'b1;
            end
            RESP:    res_valid = gnt_oh;
            default: ;
        endcase
    end

    // The flat operand packing and the [row][col] packed array share one bit layout,
    // so slices move across without reordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            gnt_oh    <= '0;
            eng_mat_a <= '0;
            eng_mat_b <= '0;
            res_c     <= '0;
            res_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        gnt_oh    <= pick_oh;
                        eng_mat_a <= op_a[pick_idx*MAT_W +: MAT_W];
                        eng_mat_b <= op_b[pick_idx*MAT_W +: MAT_W];
                    end
                end
                ISSUE: begin
                    rr_ptr  <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    if (eng_done) begin
                        res_c   <= eng_mat_c;
                        res_err <= 1'b0;
                    end else if (timeout_hit) begin
                        res_c   <= '0;
                        res_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_arbiter.sv
// Directed bench for matmul_arbiter with a small behavioural multiply engine.
module tb_matmul_arbiter;
    import matmul_pkg::*;

    localparam int NR = 2;
    localparam int EW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [63:0]   op_a, op_b;
    logic [NR-1:0] ack;
    logic [31:0]   res_c;
    logic [NR-1:0] res_valid;
    logic          res_err, busy, eng_start;
    mat2_t         eng_mat_a, eng_mat_b;
    mat2_t         eng_mat_c = '0;
    logic          eng_done;
    logic          done_m = 1'b0;
    logic          force_done;

    bit eng_en   = 1'b1;
    int eng_lat  = 2;
    bit eng_busy = 1'b0;
    int eng_cnt  = 0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    assign eng_done = done_m | force_done;

    matmul_arbiter #(.NUM_REQ(NR), .ELEM_W(EW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .ack       (ack),
        .res_c     (res_c),
        .res_valid (res_valid),
        .res_err   (res_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_mat_a (eng_mat_a),
        .eng_mat_b (eng_mat_b),
        .eng_mat_c (eng_mat_c),
        .eng_done  (eng_done)
    );

    function automatic mat2_t mmul(input mat2_t a, input mat2_t b);
        mat2_t c;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                c[i][j] = elem_t'(a[i][0] * b[0][j] + a[i][1] * b[1][j]);
        return c;
    endfunction

    // Engine stub: done pulses eng_lat cycles after a start it accepts.
    always @(posedge clk) begin
        done_m <= 1'b0;
        if (eng_start && eng_en && !eng_busy) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_busy  <= 1'b0;
                done_m    <= 1'b1;
                eng_mat_c <= mmul(eng_mat_a, eng_mat_b);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        for (n = 1; n <= 40; n++) begin
            tick();
            if (ack != '0) break;
        end
    endtask

    task automatic wait_rv(output int n);
        for (n = 1; n <= 60; n++) begin
            tick();
            if (res_valid != '0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        int quiet_bad;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; force_done = 1'b0;
        tick();
        tick();
        check_vec("rst_ack",   ack,       0);
        check_vec("rst_rv",    res_valid, 0);
        check_vec("rst_err",   res_err,   0);
        check_vec("rst_busy",  busy,      0);
        check_vec("rst_start", eng_start, 0);
        check_vec("rst_res_c", res_c,     0);
        check_vec("rst_mat_a", eng_mat_a, 0);
        check_vec("rst_mat_b", eng_mat_b, 0);
        rst = 1'b0;

        // Requester 0: all 2 times all 128 wraps every element to zero.
        op_a[31:0] = 32'h02020202;
        op_b[31:0] = 32'h80808080;
        req = 2'b01;
        wait_ack(n);
        check_vec("t1_ack",   ack,       2'b01);
        check_vec("t1_start", eng_start, 1);
        check_vec("t1_mat_a", eng_mat_a, 32'h02020202);
        check_vec("t1_mat_b", eng_mat_b, 32'h80808080);
        req = 2'b00;
        tick();
        check_vec("t1_start_pulse", eng_start, 0);
        check_vec("t1_ack_pulse",   ack,       0);
        wait_rv(n);
        check_vec("t1_rv",    res_valid, 2'b01);
        check_vec("t1_res_c", res_c,     32'h00000000);
        check_vec("t1_err",   res_err,   0);

        // Requester 1: identity times [[3,4],[5,6]].
        op_a[63:32] = 32'h01000001;
        op_b[63:32] = 32'h06050403;
        req = 2'b10;
        wait_ack(n);
        check_vec("t2_ack", ack, 2'b10);
        req = 2'b00;
        wait_rv(n);
        check_vec("t2_rv",    res_valid, 2'b10);
        check_vec("t2_res_c", res_c,     32'h06050403);

        // Both requesters held for four operations: grants alternate 0,1,0,1.
        op_a = {32'h01000001, 32'h01000001};
        op_b = {32'h0d0c0b0a, 32'h14131211};
        req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            check_vec($sformatf("rr%0d_ack", k), ack, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) check_vec($sformatf("rr%0d_gap", k), n, 2);
            wait_rv(n);
            check_vec($sformatf("rr%0d_rv", k), res_valid, (k % 2) ? 2'b10 : 2'b01);
            check_vec($sformatf("rr%0d_res_c", k), res_c, (k % 2) ? 32'h0d0c0b0a : 32'h14131211);
        end
        req = 2'b00;

        // Engine never completes: timeout after exactly 8 WAIT cycles.
        eng_en = 1'b0;
        op_a[31:0] = 32'h01010101;
        req = 2'b01;
        wait_ack(n);
        check_vec("tmo_ack", ack, 2'b01);
        req = 2'b00;
        wait_rv(n);
        check_vec("tmo_latency", n, TO + 1);
        check_vec("tmo_rv",    res_valid, 2'b01);
        check_vec("tmo_err",   res_err,   1);
        check_vec("tmo_res_c", res_c,     0);
        check_vec("tmo_busy",  busy,      1);
        tick();
        check_vec("tmo_busy_drop", busy, 0);
        eng_en = 1'b1;

        // General product on requester 1 also clears res_err.
        op_a[63:32] = 32'h04030201;
        op_b[63:32] = 32'h08070605;
        req = 2'b10;
        wait_ack(n);
        check_vec("mul_ack", ack, 2'b10);
        req = 2'b00;
        wait_rv(n);
        check_vec("mul_rv",    res_valid, 2'b10);
        check_vec("mul_res_c", res_c,     32'h322b1613);
        check_vec("mul_err",   res_err,   0);

        // Reset during WAIT; the engine's late done must be ignored.
        eng_lat = 15;
        op_a[31:0] = 32'h01000001;
        op_b[31:0] = 32'h44332211;
        req = 2'b01;
        wait_ack(n);
        check_vec("mrst_ack", ack, 2'b01);
        req = 2'b00;
        tick();
        tick();
        check_vec("mrst_in_wait", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("mrst_ack0",   ack,       0);
        check_vec("mrst_rv0",    res_valid, 0);
        check_vec("mrst_busy0",  busy,      0);
        check_vec("mrst_start0", eng_start, 0);
        check_vec("mrst_err0",   res_err,   0);
        check_vec("mrst_res_c0", res_c,     0);
        check_vec("mrst_mat_a0", eng_mat_a, 0);
        quiet_bad = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (res_valid != '0 || busy) quiet_bad++;
        end
        check_vec("mrst_quiet", quiet_bad, 0);
        eng_lat = 2;
        op_a[63:32] = 32'h01000001;
        op_b[63:32] = 32'h06050403;
        req = 2'b10;
        wait_ack(n);
        check_vec("post_rst_ack", ack, 2'b10);
        req = 2'b00;
        wait_rv(n);
        check_vec("post_rst_rv",    res_valid, 2'b10);
        check_vec("post_rst_res_c", res_c,     32'h06050403);
        tick();

        // Spurious done while idle with no request.
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check_vec("spur_busy",  busy,      0);
        check_vec("spur_ack",   ack,       0);
        check_vec("spur_rv",    res_valid, 0);
        check_vec("spur_start", eng_start, 0);
        check_vec("spur_res_c", res_c,     32'h06050403);
        tick();
        check_vec("spur_busy2", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
